// File: rtl/mem_checker_pkg.sv
// Shared definitions for the memory checker transaction stage: op encoding,
// FSM states and the 8-bit pattern LFSR.
package mem_checker_pkg;

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_WR_RD = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StDone
    } state_e;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] p);
        return {p[6:0], p[6] ^ p[1] ^ p[0]};
    endfunction

endpackage

// File: rtl/ptrn_gen.sv
// 8-bit data pattern source: loads a seed, then either holds it or walks the LFSR
// one step per consumed beat.
module ptrn_gen
    import mem_checker_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       step_i,
    input  logic       rnd_i,
    output logic [7:0] pattern_o
);

    logic [7:0] pattern_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pattern_q <= '0;
        end else if (load_i) begin
            pattern_q <= seed_i;
        end else if (step_i && rnd_i) begin
            pattern_q <= lfsr8_next(pattern_q);
        end
    end

    assign pattern_o = pattern_q;

endmodule

// File: rtl/mem_txn_master.sv
// Executes one write / read / write-then-read burst command on an Avalon-MM master
// and checks read data against the regenerated pattern.
module mem_txn_master
    import mem_checker_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_W   = 4,
    parameter int unsigned ERR_CNT_W = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [ADDR_W-1:0]    cmd_addr_i,
    input  logic [BURST_W-1:0]   cmd_burst_i,
    input  logic [7:0]           cmd_seed_i,
    input  logic                 cmd_rnd_i,
    output logic                 write_master,
    output logic                 read_master,
    output logic [ADDR_W-1:0]    address_master,
    output logic [DATA_W-1:0]    writedata_master,
    output logic [BURST_W-1:0]   burstcount_master,
    input  logic                 waitrequest_master,
    input  logic [DATA_W-1:0]    readdata_master,
    input  logic                 readdatavalid_master,
    output logic                 done_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 first_err_valid_o,
    output logic [ADDR_W-1:0]    first_err_addr_o,
    output logic                 timeout_o,
    input  logic                 clr_stat_i
);

    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned NBYTES = DATA_W / 8;

    state_e             state_q;
    logic [1:0]         op_q;
    logic               rnd_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] beats_q;
    logic [TO_W-1:0]    idle_q;

    logic [7:0]         wr_pat;
    logic [7:0]         exp_pat;
    logic               accept;
    logic               wr_beat;
    logic               rd_beat;
    logic               mismatch;
    logic               timeout_hit;
    logic               last_beat;
    logic [BURST_W-1:0] burst_eff;

    assign accept      = (state_q == StIdle) && cmd_valid_i;
    assign wr_beat     = (state_q == StWr) && !waitrequest_master;
    assign rd_beat     = (state_q == StRdWait) && readdatavalid_master;
    assign mismatch    = rd_beat && (readdata_master != {NBYTES{exp_pat}});
    assign timeout_hit = (state_q == StRdWait) && !readdatavalid_master &&
                         (idle_q == TO_W'(TIMEOUT - 1));
    assign last_beat   = (beats_q == BURST_W'(1));
    assign burst_eff   = (cmd_burst_i == '0) ? BURST_W'(1) : cmd_burst_i;

    assign writedata_master = {NBYTES{wr_pat}};

    ptrn_gen u_wr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept),
        .seed_i    (cmd_seed_i),
        .step_i    (wr_beat),
        .rnd_i     (rnd_q),
        .pattern_o (wr_pat)
    );

    // Loaded at accept and untouched during the write phase, so a WR_RD readback
    // starts again from the seed.
    ptrn_gen u_exp_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept),
        .seed_i    (cmd_seed_i),
        .step_i    (rd_beat),
        .rnd_i     (rnd_q),
        .pattern_o (exp_pat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= StIdle;
            op_q              <= '0;
            rnd_q             <= 1'b0;
            burst_q           <= '0;
            beats_q           <= '0;
            idle_q            <= '0;
            cmd_ready_o       <= 1'b1;
            write_master      <= 1'b0;
            read_master       <= 1'b0;
            address_master    <= '0;
            burstcount_master <= '0;
            done_o            <= 1'b0;
            err_cnt_o         <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
            timeout_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        op_q              <= cmd_op_i;
                        rnd_q             <= cmd_rnd_i;
                        burst_q           <= burst_eff;
                        beats_q           <= burst_eff;
                        address_master    <= cmd_addr_i;
                        burstcount_master <= burst_eff;
                        cmd_ready_o       <= 1'b0;
                        if (cmd_op_i == OP_WR || cmd_op_i == OP_WR_RD) begin
                            state_q      <= StWr;
                            write_master <= 1'b1;
                        end else begin
                            state_q     <= StRd;
                            read_master <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    if (!waitrequest_master) begin
                        if (last_beat) begin
                            write_master <= 1'b0;
                            if (op_q == OP_WR_RD) begin
                                state_q     <= StRd;
                                read_master <= 1'b1;
                                beats_q     <= burst_q;
                            end else begin
                                state_q <= StDone;
                            end
                        end else begin
                            beats_q <= beats_q - BURST_W'(1);
                        end
                    end
                end
                StRd: begin
                    if (!waitrequest_master) begin
                        read_master <= 1'b0;
                        idle_q      <= '0;
                        state_q     <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (readdatavalid_master) begin
                        idle_q <= '0;
                        if (last_beat) begin
                            state_q <= StDone;
                        end else begin
                            beats_q <= beats_q - BURST_W'(1);
                        end
                    end else if (timeout_hit) begin
                        state_q <= StDone;
                    end else begin
                        idle_q <= idle_q + TO_W'(1);
                    end
                end
                StDone: begin
                    done_o      <= 1'b1;
                    cmd_ready_o <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // A clear wins over a mismatch or timeout in the same cycle.
            if (clr_stat_i) begin
                err_cnt_o         <= '0;
                first_err_valid_o <= 1'b0;
                first_err_addr_o  <= '0;
                timeout_o         <= 1'b0;
            end else begin
                if (mismatch) begin
                    if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                    end
                    if (!first_err_valid_o) begin
                        first_err_valid_o <= 1'b1;
                        first_err_addr_o  <= address_master;
                    end
                end
                if (timeout_hit) begin
                    timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule
